// File: rtl/dff_monitor_if.sv
// Event record channel from dff_monitor to its consumer (scoreboard or debug port).
interface dff_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_code;
  logic [CNT_W-1:0] evt_time;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_time,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_time,
    output evt_ready
  );
endinterface

// File: rtl/dff_monitor.sv
// Observer for a dff stage: edge detection on q, q/qb complement checking, saturating
// event counters, sticky flags and a small time-stamped event FIFO.
module dff_monitor #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q,
  input  logic             qb,
  input  logic             clear,
  dff_monitor_if.master    evt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic             ovf_flag
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam logic [OccW-1:0]  OccFull = OccW'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [CNT_W-1:0] timer_q;
  logic             q_prev_q;
  logic             armed_q;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic [CNT_W-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             err_flag_q, err_flag_d;
  logic             ovf_flag_q, ovf_flag_d;

  logic [1:0]       mem_code [DEPTH];
  logic [CNT_W-1:0] mem_time [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]  occ_q, occ_d;

  logic       is_err, is_rise, is_fall;
  logic       push_req, do_push, do_pop, drop;
  logic [1:0] push_code;

  // Event classification; edges are only reported once prev_q holds a real sample.
  always_comb begin
    is_err    = (q == qb);
    is_rise   = armed_q && !q_prev_q && q;
    is_fall   = armed_q && q_prev_q && !q;
    push_req  = is_err || is_rise || is_fall;
    // Errors win the single FIFO slot; a coincident edge is counted only.
    push_code = is_err ? 2'b11 : (is_rise ? 2'b01 : 2'b10);
    do_pop    = (occ_q != '0) && evt.evt_ready;
    // When full, a push fits only if the head leaves on the same edge.
    do_push   = push_req && ((occ_q != OccFull) || do_pop);
    drop      = push_req && !do_push;
    occ_d     = occ_q + OccW'(do_push) - OccW'(do_pop);
  end

  // Next state of counters and sticky flags; clear overrides any same-cycle update.
  always_comb begin
    rise_d     = rise_q;
    fall_d     = fall_q;
    err_d      = err_q;
    err_flag_d = err_flag_q;
    ovf_flag_d = ovf_flag_q;
    if (clear) begin
      rise_d     = '0;
      fall_d     = '0;
      err_d      = '0;
      err_flag_d = 1'b0;
      ovf_flag_d = 1'b0;
    end else begin
      if (is_rise && (rise_q != CntMax)) rise_d = rise_q + CNT_W'(1);
      if (is_fall && (fall_q != CntMax)) fall_d = fall_q + CNT_W'(1);
      if (is_err && (err_q != CntMax))   err_d  = err_q + CNT_W'(1);
      if (is_err) err_flag_d = 1'b1;
      if (drop)   ovf_flag_d = 1'b1;
    end
  end

  // Control state: timer, edge history, counters, flags and FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q    <= '0;
      q_prev_q   <= 1'b0;
      armed_q    <= 1'b0;
      rise_q     <= '0;
      fall_q     <= '0;
      err_q      <= '0;
      err_flag_q <= 1'b0;
      ovf_flag_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      timer_q    <= timer_q + CNT_W'(1);
      q_prev_q   <= q;
      armed_q    <= 1'b1;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
      ovf_flag_q <= ovf_flag_d;
      occ_q      <= occ_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // FIFO storage; contents are don't-care while occupancy says the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_code[wr_ptr_q] <= push_code;
      mem_time[wr_ptr_q] <= timer_q;
    end
  end

  // Outputs; head fields are forced to zero when nothing is queued.
  always_comb begin
    evt.evt_valid = (occ_q != '0);
    evt.evt_code  = evt.evt_valid ? mem_code[rd_ptr_q] : 2'b00;
    evt.evt_time  = evt.evt_valid ? mem_time[rd_ptr_q] : '0;
    rise_cnt      = rise_q;
    fall_cnt      = fall_q;
    err_cnt       = err_q;
    err_flag      = err_flag_q;
    ovf_flag      = ovf_flag_q;
  end

endmodule

// File: tb/tb_dff_monitor.sv
// Randomised and directed bench for dff_monitor with a queue-based reference model.
module tb_dff_monitor;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          MAXV  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             q, qb, clear;
  logic [CNT_W-1:0] rise_cnt, fall_cnt, err_cnt;
  logic             err_flag, ovf_flag;

  dff_monitor_if #(.CNT_W(CNT_W)) evt ();

  dff_monitor #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .q        (q),
    .qb       (qb),
    .clear    (clear),
    .evt      (evt.master),
    .rise_cnt (rise_cnt),
    .fall_cnt (fall_cnt),
    .err_cnt  (err_cnt),
    .err_flag (err_flag),
    .ovf_flag (ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: records still owed by the DUT, plus counter/flag expectations.
  typedef struct {int code; int t;} rec_t;
  rec_t exp_q[$];
  int   m_timer = 0, m_prev = 0, m_armed = 0;
  int   m_rise = 0, m_fall = 0, m_err = 0, m_eflag = 0, m_oflag = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_timer = 0; m_prev = 0; m_armed = 0;
      m_rise = 0; m_fall = 0; m_err = 0; m_eflag = 0; m_oflag = 0;
      exp_q.delete();
    end else begin
      int e, r, f;
      rec_t rec;
      e = (q == qb) ? 1 : 0;
      r = (m_armed != 0 && m_prev == 0 && q == 1'b1) ? 1 : 0;
      f = (m_armed != 0 && m_prev == 1 && q == 1'b0) ? 1 : 0;
      if (clear) begin
        m_rise = 0; m_fall = 0; m_err = 0; m_eflag = 0; m_oflag = 0;
      end else begin
        if (r != 0) m_rise = (m_rise < MAXV) ? m_rise + 1 : MAXV;
        if (f != 0) m_fall = (m_fall < MAXV) ? m_fall + 1 : MAXV;
        if (e != 0) begin
          m_err   = (m_err < MAXV) ? m_err + 1 : MAXV;
          m_eflag = 1;
        end
      end
      if (e != 0 || r != 0 || f != 0) begin
        rec.code = (e != 0) ? 3 : ((r != 0) ? 1 : 2);
        rec.t    = m_timer;
        // Any pop due this edge was already taken off exp_q by the monitor.
        if (exp_q.size() < DEPTH) exp_q.push_back(rec);
        else if (!clear) m_oflag = 1;
      end
      m_prev  = q ? 1 : 0;
      m_armed = 1;
      m_timer = (m_timer + 1) % (MAXV + 1);
    end
  end

  // Monitor: compares the presented head and status, retires the head on handshake.
  always @(negedge clk) begin
    chk("evt_valid", int'(evt.evt_valid), (exp_q.size() != 0) ? 1 : 0);
    if (exp_q.size() != 0) begin
      chk("evt_code", int'(evt.evt_code), exp_q[0].code);
      chk("evt_time", int'(evt.evt_time), exp_q[0].t);
      if (evt.evt_ready) void'(exp_q.pop_front());
    end else begin
      chk("evt_code_empty", int'(evt.evt_code), 0);
      chk("evt_time_empty", int'(evt.evt_time), 0);
    end
    chk("rise_cnt", int'(rise_cnt), m_rise);
    chk("fall_cnt", int'(fall_cnt), m_fall);
    chk("err_cnt",  int'(err_cnt),  m_err);
    chk("err_flag", int'(err_flag), m_eflag);
    chk("ovf_flag", int'(ovf_flag), m_oflag);
  end

  task automatic step(input logic nq, input logic nqb, input logic nrdy, input logic nclr);
    q             = nq;
    qb            = nqb;
    evt.evt_ready = nrdy;
    clear         = nclr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    q = 1'b0; qb = 1'b1; clear = 1'b0; evt.evt_ready = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Quiet complementary input: arming only, no events.
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);

    // One rise and one fall held in the FIFO, then drained in order.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Two complement-error cycles, the first coincident with a rise.
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0);

    // Overflow: six edges into a four-entry FIFO, then push+pop while full.
    for (int i = 0; i < 6; i++) begin
      step(i[0], ~i[0], 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Saturation of the edge counters.
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk("rise_saturated", int'(rise_cnt), MAXV);
    chk("fall_saturated", int'(fall_cnt), MAXV);

    // Clear coincident with a rise wins.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rise_after_clear", int'(rise_cnt), 0);
    chk("ovf_after_clear", int'(ovf_flag), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);

    // Three queued events, then an asynchronous reset between edges.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_evt_valid", int'(evt.evt_valid), 0);
    chk("async_rise_cnt",  int'(rise_cnt), 0);
    chk("async_fall_cnt",  int'(fall_cnt), 0);
    chk("async_err_cnt",   int'(err_cnt), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    // q differs from the reset value of prev_q, yet the arming edge reports nothing.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("arm_no_rise", int'(rise_cnt), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Random traffic with occasional errors and clears.
    for (int i = 0; i < 400; i++) begin
      logic nq, nqb;
      nq  = 1'($urandom_range(0, 1));
      nqb = ($urandom_range(0, 7) == 0) ? nq : ~nq;
      step(nq, nqb, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end
    repeat (8) step(q, ~q, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
